// File: rtl/lc3b_line_responder_pkg.sv
// Shared LC-3b line/address types plus responder FSM and port encodings.
// Imported by the line responder and its storage array.
package lc3b_types;

    typedef logic [127:0] lc3b_line;
    typedef logic [127:0] lc3b_c_line;
    typedef logic [11:0]  lc3b_wb_adr;
    typedef logic [15:0]  lc3b_word;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } lc3b_resp_state;

    typedef enum logic {
        PORT_IFETCH,
        PORT_DATA
    } lc3b_port;

endpackage

// File: rtl/lc3b_line_responder_storage.sv
// Single-port line array with byte-lane write merge.
// The read/merged line is registered on the access edge.
module line_storage
    import lc3b_types::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  lc3b_word              mask,
    input  lc3b_c_line            wdata,
    output lc3b_line              rdata
);

    lc3b_line mem [2**DEPTH_LOG2];
    lc3b_line cur;
    lc3b_line merged;

    assign cur = mem[addr];

    always_comb begin
        merged = cur;
        for (int i = 0; i < 16; i++) begin
            if (mask[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en && we) mem[addr] <= merged;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= we ? merged : cur;
        end
    end

endmodule

// File: rtl/lc3b_line_responder.sv
// Fetch/data line responder: fixed-priority arbitration,
// programmable latency, one-cycle completion pulse per port.
module lc3b_line_responder
    import lc3b_types::*;
#(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ifetch_read,
    input  lc3b_wb_adr ifetch_address,
    output lc3b_line   ifetch_rdata,
    output logic       ifetch_resp,
    input  logic       mem_read,
    input  logic       mem_write,
    input  lc3b_wb_adr mem_address,
    input  lc3b_c_line mem_wdata,
    input  lc3b_word   mem_sel,
    output lc3b_line   mem_rdata,
    output logic       mem_resp
);

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    lc3b_resp_state state;
    lc3b_resp_state state_n;
    logic [7:0]     cnt;
    logic [7:0]     cnt_n;
    logic           access;

    lc3b_port   owner;
    lc3b_wb_adr addr_q;
    lc3b_c_line wdata_q;
    lc3b_word   sel_q;
    logic       we_q;

    lc3b_line line_q;
    lc3b_line ifetch_hold;
    lc3b_line mem_hold;
    logic     in_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        access  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read || mem_write || ifetch_read) begin
                    state_n = BUSY;
                    cnt_n   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt == 8'd0) begin
                    access  = 1'b1;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Requests are captured only in IDLE; data port wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner   <= PORT_IFETCH;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
        end else if (state == IDLE) begin
            wdata_q <= mem_wdata;
            sel_q   <= mem_sel;
            if (mem_read || mem_write) begin
                owner  <= PORT_DATA;
                addr_q <= mem_address;
                we_q   <= mem_write;
            end else if (ifetch_read) begin
                owner  <= PORT_IFETCH;
                addr_q <= ifetch_address;
                we_q   <= 1'b0;
            end
        end
    end

    line_storage #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_store (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (access),
        .we   (we_q),
        .addr (addr_q[DEPTH_LOG2-1:0]),
        .mask (sel_q),
        .wdata(wdata_q),
        .rdata(line_q)
    );

    // Holding copies keep each port's last line once RESP ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifetch_hold <= '0;
            mem_hold    <= '0;
        end else if (state == RESP) begin
            if (owner == PORT_DATA) mem_hold <= line_q;
            else                    ifetch_hold <= line_q;
        end
    end

    assign in_resp      = (state == RESP);
    assign ifetch_resp  = in_resp && (owner == PORT_IFETCH);
    assign mem_resp     = in_resp && (owner == PORT_DATA);
    assign ifetch_rdata = ifetch_resp ? line_q : ifetch_hold;
    assign mem_rdata    = mem_resp ? line_q : mem_hold;

endmodule

// File: tb/tb_lc3b_line_responder.sv
// Bench for lc3b_line_responder: vector table, corner sequences
// and randomized accesses against a line-array reference model.
module tb_lc3b_line_responder;
    import lc3b_types::*;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ifetch_read = 1'b0;
    lc3b_wb_adr ifetch_address = '0;
    lc3b_line   ifetch_rdata;
    logic       ifetch_resp;
    logic       mem_read = 1'b0;
    logic       mem_write = 1'b0;
    lc3b_wb_adr mem_address = '0;
    lc3b_c_line mem_wdata = '0;
    lc3b_word   mem_sel = '0;
    lc3b_line   mem_rdata;
    logic       mem_resp;

    int n_tests = 0;
    int n_fail = 0;

    lc3b_line mem_m [16];
    lc3b_line exp_if_hold = '0;
    lc3b_line exp_mem_hold = '0;

    typedef struct {
        bit         dport;
        bit         wr;
        lc3b_wb_adr a;
        lc3b_line   wd;
        lc3b_word   sel;
        lc3b_line   exp;
    } vec_t;

    vec_t tbl [8];

    lc3b_line_responder #(
        .LATENCY   (LAT),
        .DEPTH_LOG2(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifetch_read   (ifetch_read),
        .ifetch_address(ifetch_address),
        .ifetch_rdata  (ifetch_rdata),
        .ifetch_resp   (ifetch_resp),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_wdata     (mem_wdata),
        .mem_sel       (mem_sel),
        .mem_rdata     (mem_rdata),
        .mem_resp      (mem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_req();
        ifetch_read = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
    endtask

    // Reference: a line is 16 bytes, a write replaces the selected bytes.
    function automatic lc3b_line model_access(input bit wr, input lc3b_wb_adr a,
                                              input lc3b_line wd, input lc3b_word sel);
        int idx = int'(a) % 16;
        if (wr) begin
            for (int b = 0; b < 16; b++) begin
                if (sel[b]) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
        return mem_m[idx];
    endfunction

    // Called at a negedge while the DUT is idle; returns at a negedge, idle.
    task automatic run(input bit dport, input bit wr, input bit rd_too,
                       input lc3b_wb_adr a, input lc3b_line wd, input lc3b_word sel,
                       input bit drop, input lc3b_line exp, input string tag);
        int       k_resp = 0;
        bit       other = 1'b0;
        lc3b_line got = '0;
        lc3b_line other_q = '0;
        if (dport) begin
            mem_read    = !wr || rd_too;
            mem_write   = wr;
            mem_address = a;
            mem_wdata   = wd;
            mem_sel     = sel;
        end else begin
            ifetch_read    = 1'b1;
            ifetch_address = a;
        end
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (drop && k == 1) clear_req();
            if (dport ? ifetch_resp : mem_resp) other = 1'b1;
            if (dport ? mem_resp : ifetch_resp) begin
                k_resp  = k;
                got     = dport ? mem_rdata : ifetch_rdata;
                other_q = dport ? ifetch_rdata : mem_rdata;
                clear_req();
                break;
            end
        end
        clear_req();
        check({tag, "_latency"}, 128'(k_resp), 128'(LAT + 1));
        check({tag, "_data"}, got, exp);
        check({tag, "_other_rdata"}, other_q, dport ? exp_if_hold : exp_mem_hold);
        check({tag, "_other_resp"}, 128'(other), 128'(0));
        if (dport) exp_mem_hold = exp;
        else       exp_if_hold = exp;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_pulse_width"}, 128'(dport ? mem_resp : ifetch_resp), 128'(0));
        check({tag, "_hold"}, dport ? mem_rdata : ifetch_rdata, exp);
    endtask

    initial begin
        lc3b_line db;
        lc3b_line pat;
        lc3b_line v0;
        lc3b_line v1;
        lc3b_line wd;
        lc3b_line exp;
        int       km;
        int       kf;
        lc3b_line gm;
        lc3b_line gf;

        db  = 128'h0123_4567_89AB_CDEF_0011_2233_DEAD_BEEF;
        pat = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
        tbl[0] = '{1'b1, 1'b1, 12'h010, db, 16'hFFFF, db};
        tbl[1] = '{1'b0, 1'b0, 12'h010, '0, 16'h0000, db};
        tbl[2] = '{1'b1, 1'b1, 12'h020, '0, 16'hFFFF, 128'h0};
        tbl[3] = '{1'b1, 1'b1, 12'h020, '1, 16'h0005, 128'h00FF_00FF};
        tbl[4] = '{1'b1, 1'b0, 12'h020, '0, 16'h0000, 128'h00FF_00FF};
        tbl[5] = '{1'b1, 1'b1, 12'h001, pat, 16'hFFFF, pat};
        tbl[6] = '{1'b0, 1'b0, 12'h011, '0, 16'h0000, pat};
        tbl[7] = '{1'b1, 1'b1, 12'h021, '1, 16'h0000, pat};

        #12;
        check("reset_ifetch_resp", 128'(ifetch_resp), 128'(0));
        check("reset_mem_resp", 128'(mem_resp), 128'(0));
        check("reset_ifetch_rdata", ifetch_rdata, 128'h0);
        check("reset_mem_rdata", mem_rdata, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run(tbl[i].dport, tbl[i].wr, 1'b0, tbl[i].a, tbl[i].wd,
                tbl[i].sel, 1'b0, tbl[i].exp, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            mem_m[i] = {$urandom, $urandom, $urandom, $urandom};
            run(1'b1, 1'b1, 1'b0, 12'(i), mem_m[i], 16'hFFFF, 1'b0,
                mem_m[i], "preload");
        end

        wd  = {$urandom, $urandom, $urandom, $urandom};
        exp = model_access(1'b1, 12'h030, wd, 16'hFFFF);
        run(1'b1, 1'b1, 1'b0, 12'h030, wd, 16'hFFFF, 1'b1, exp, "drop_wr");
        run(1'b0, 1'b0, 1'b0, 12'h030, '0, 16'h0, 1'b0, mem_m[0], "drop_rd");

        ifetch_read    = 1'b1;
        ifetch_address = 12'h005;
        mem_read       = 1'b1;
        mem_address    = 12'h006;
        km = 0;
        kf = 0;
        gm = '0;
        gf = '0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_resp && km == 0) begin
                km = k;
                gm = mem_rdata;
                mem_read = 1'b0;
            end
            if (ifetch_resp && kf == 0) begin
                kf = k;
                gf = ifetch_rdata;
                ifetch_read = 1'b0;
                break;
            end
        end
        clear_req();
        check("contend_mem_lat", 128'(km), 128'(LAT + 1));
        check("contend_if_lat", 128'(kf), 128'(2 * LAT + 3));
        check("contend_mem_data", gm, mem_m[6]);
        check("contend_if_data", gf, mem_m[5]);
        exp_mem_hold = mem_m[6];
        exp_if_hold  = mem_m[5];
        @(negedge clk);

        v0 = {$urandom, $urandom, $urandom, $urandom};
        v1 = ~v0;
        exp = model_access(1'b1, 12'h003, v0, 16'hFFFF);
        run(1'b1, 1'b1, 1'b0, 12'h003, v0, 16'hFFFF, 1'b0, exp, "rst_pre");
        mem_write   = 1'b1;
        mem_address = 12'h003;
        mem_wdata   = v1;
        mem_sel     = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_resp", 128'(mem_resp), 128'(0));
        check("midrst_if_resp", 128'(ifetch_resp), 128'(0));
        check("midrst_mem_rdata", mem_rdata, 128'h0);
        check("midrst_if_rdata", ifetch_rdata, 128'h0);
        clear_req();
        exp_mem_hold = '0;
        exp_if_hold  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(1'b0, 1'b0, 1'b0, 12'h003, '0, 16'h0, 1'b0, mem_m[3], "midrst_rd");

        for (int i = 0; i < 40; i++) begin
            bit         dp;
            bit         wr;
            bit         both;
            bit         dr;
            lc3b_wb_adr a;
            lc3b_word   sel;
            dp   = 1'($urandom);
            wr   = dp && ($urandom_range(0, 2) != 0);
            both = wr && 1'($urandom);
            dr   = ($urandom_range(0, 3) == 0);
            a    = 12'($urandom);
            sel  = 16'($urandom);
            wd   = {$urandom, $urandom, $urandom, $urandom};
            exp  = model_access(wr, a, wd, sel);
            run(dp, wr, both, a, wd, sel, dr, exp, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
